// File: rtl/platform_layer_painter.sv
// platform_layer_painter
// Produces per-pixel platform colour and transparency for the current beam
// position. Game logic fills a shadow table of platforms; a commit publishes
// the shadow into the active table at the next frame start, so a frame is
// always drawn from one consistent table. The lookup is a two-stage pipeline
// and the beam coordinates and draw flag are delayed to match it.
module platform_layer_painter #(
  parameter int              NUM_PLATFORMS = 8,
  parameter int              PLAT_W        = 60,
  parameter int              PLAT_H        = 12,
  parameter logic [2:0][3:0] BODY_COLOR    = {4'h2, 4'hC, 4'h6},
  parameter logic [2:0][3:0] EDGE_COLOR    = {4'h1, 4'h7, 4'h2}
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [10:0]                    beam_x,
  input  logic [9:0]                     beam_y,
  input  logic                           draw,
  input  logic                           frame_start,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [$clog2(NUM_PLATFORMS)-1:0] wr_index,
  input  logic [10:0]                    wr_x,
  input  logic [9:0]                     wr_y,
  input  logic                           wr_active,
  input  logic                           commit,
  output logic                           commit_pending,
  output logic [10:0]                    beam_x_out,
  output logic [9:0]                     beam_y_out,
  output logic                           draw_out,
  output logic [2:0][3:0]                platform_colors,
  output logic                           platform_transparencies
);

  // One table slot: left column, top row, enable.
  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        active;
  } slot_t;

  // Sums are one bit wider than the coordinates so a platform hanging off
  // the right or bottom edge never wraps back onto column or row 0.
  localparam logic [11:0] PLAT_W_12   = 12'(PLAT_W);
  localparam logic [10:0] PLAT_H_11   = 11'(PLAT_H);
  localparam logic [10:0] PLAT_H_M1   = 11'(PLAT_H - 1);

  slot_t shadow_tbl [NUM_PLATFORMS];
  slot_t active_tbl [NUM_PLATFORMS];
  slot_t view_tbl   [NUM_PLATFORMS];

  logic                     apply_commit;
  logic [NUM_PLATFORMS-1:0] hit_comb;
  logic [NUM_PLATFORMS-1:0] edge_comb;

  // Stage 1 registers
  logic [10:0]              bx_s1;
  logic [9:0]               by_s1;
  logic                     draw_s1;
  logic [NUM_PLATFORMS-1:0] hit_s1;
  logic [NUM_PLATFORMS-1:0] edge_s1;

  // Stage 2 selection results
  logic                     sel_found;
  logic                     sel_edge;

  // Writes are refused while a commit waits, so the published shadow is
  // exactly what game logic had when it committed.
  assign wr_ready     = ~commit_pending;
  assign apply_commit = frame_start & commit_pending;

  // Shadow table: accepts handshaked writes from game logic.
  // NOTE: the tables are small register files, not RAM, so they are reset
  // explicitly; a RAM macro would need a clear sequence instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLATFORMS; i++) shadow_tbl[i] <= '0;
    end else if (wr_valid && wr_ready) begin
      shadow_tbl[wr_index] <= '{x: wr_x, y: wr_y, active: wr_active};
    end
  end

  // Active table and commit flag: publish the shadow on a frame start.
  // NOTE: non-blocking assignments keep every register in this clock domain
  // reading pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLATFORMS; i++) active_tbl[i] <= '0;
      commit_pending <= 1'b0;
    end else if (apply_commit) begin
      active_tbl     <= shadow_tbl;
      commit_pending <= 1'b0;
    end else if (commit) begin
      commit_pending <= 1'b1;
    end
  end

  // Table as seen by the pixel presented this cycle: a frame-start pixel
  // already sees the table that is being published on this edge.
  // NOTE: every output of a combinational block gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    for (int i = 0; i < NUM_PLATFORMS; i++) begin
      view_tbl[i] = apply_commit ? shadow_tbl[i] : active_tbl[i];
    end
  end

  // Per-slot rectangle hit and edge-row test for the incoming pixel.
  always_comb begin
    hit_comb  = '0;
    edge_comb = '0;
    for (int i = 0; i < NUM_PLATFORMS; i++) begin
      hit_comb[i] = view_tbl[i].active
                  && ({1'b0, beam_x} >= {1'b0, view_tbl[i].x})
                  && ({1'b0, beam_x} <  ({1'b0, view_tbl[i].x} + PLAT_W_12))
                  && ({1'b0, beam_y} >= {1'b0, view_tbl[i].y})
                  && ({1'b0, beam_y} <  ({1'b0, view_tbl[i].y} + PLAT_H_11));
      edge_comb[i] = (beam_y == view_tbl[i].y)
                  || ({1'b0, beam_y} == ({1'b0, view_tbl[i].y} + PLAT_H_M1));
    end
  end

  // Stage 1: register beam, draw and the per-slot hit/edge vectors.
  always_ff @(posedge clk) begin
    if (reset) begin
      bx_s1   <= '0;
      by_s1   <= '0;
      draw_s1 <= 1'b0;
      hit_s1  <= '0;
      edge_s1 <= '0;
    end else begin
      bx_s1   <= beam_x;
      by_s1   <= beam_y;
      draw_s1 <= draw;
      hit_s1  <= hit_comb;
      edge_s1 <= edge_comb;
    end
  end

  // Priority select: scanning downward lets the lowest-index hit win.
  always_comb begin
    sel_found = 1'b0;
    sel_edge  = 1'b0;
    for (int i = NUM_PLATFORMS - 1; i >= 0; i--) begin
      if (hit_s1[i]) begin
        sel_found = 1'b1;
        sel_edge  = edge_s1[i];
      end
    end
  end

  // Stage 2: register colour, transparency and the aligned beam signals.
  always_ff @(posedge clk) begin
    if (reset) begin
      beam_x_out              <= '0;
      beam_y_out              <= '0;
      draw_out                <= 1'b0;
      platform_colors         <= '0;
      platform_transparencies <= 1'b1;
    end else begin
      beam_x_out <= bx_s1;
      beam_y_out <= by_s1;
      draw_out   <= draw_s1;
      if (draw_s1 && sel_found) begin
        platform_colors         <= sel_edge ? EDGE_COLOR : BODY_COLOR;
        platform_transparencies <= 1'b0;
      end else begin
        platform_colors         <= '0;
        platform_transparencies <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_platform_layer_painter.sv
// Directed self-checking bench for platform_layer_painter.
module tb_platform_layer_painter;

  logic            clk = 1'b0;
  logic            reset;
  logic [10:0]     beam_x;
  logic [9:0]      beam_y;
  logic            draw;
  logic            frame_start;
  logic            wr_valid;
  logic            wr_ready;
  logic [2:0]      wr_index;
  logic [10:0]     wr_x;
  logic [9:0]      wr_y;
  logic            wr_active;
  logic            commit;
  logic            commit_pending;
  logic [10:0]     beam_x_out;
  logic [9:0]      beam_y_out;
  logic            draw_out;
  logic [2:0][3:0] platform_colors;
  logic            platform_transparencies;
  logic [11:0]     col;

  int checks = 0;
  int errors = 0;

  localparam logic [11:0] EDGE = 12'h172;
  localparam logic [11:0] BODY = 12'h2C6;
  localparam logic [11:0] NONE = 12'h000;

  always #5 clk = ~clk;
  assign col = platform_colors;

  platform_layer_painter dut (
    .clk                     (clk),
    .reset                   (reset),
    .beam_x                  (beam_x),
    .beam_y                  (beam_y),
    .draw                    (draw),
    .frame_start             (frame_start),
    .wr_valid                (wr_valid),
    .wr_ready                (wr_ready),
    .wr_index                (wr_index),
    .wr_x                    (wr_x),
    .wr_y                    (wr_y),
    .wr_active               (wr_active),
    .commit                  (commit),
    .commit_pending          (commit_pending),
    .beam_x_out              (beam_x_out),
    .beam_y_out              (beam_y_out),
    .draw_out                (draw_out),
    .platform_colors         (platform_colors),
    .platform_transparencies (platform_transparencies)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel (any frame_start/commit/write already driven goes with
  // it for one cycle), then check the result two cycles later.
  task automatic px(input logic [10:0] x, input logic [9:0] y, input logic d,
                    input logic exp_t, input logic [11:0] exp_c, input string tag);
    beam_x = x;
    beam_y = y;
    draw   = d;
    tick();
    frame_start = 1'b0;
    commit      = 1'b0;
    wr_valid    = 1'b0;
    tick();
    check({tag, "_transp"}, 32'(platform_transparencies), 32'(exp_t));
    check({tag, "_color"}, 32'(col), 32'(exp_c));
  endtask

  task automatic write_slot(input logic [2:0] idx, input logic [10:0] x,
                            input logic [9:0] y, input logic act);
    wr_valid  = 1'b1;
    wr_index  = idx;
    wr_x      = x;
    wr_y      = y;
    wr_active = act;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  logic [10:0] hx [24];
  logic [9:0]  hy [24];
  logic        hd [24];

  initial begin
    reset = 1'b1; beam_x = '0; beam_y = '0; draw = 1'b0; frame_start = 1'b0;
    wr_valid = 1'b0; wr_index = '0; wr_x = '0; wr_y = '0; wr_active = 1'b0;
    commit = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_pending", 32'(commit_pending), 32'd0);
    check("rst_transp", 32'(platform_transparencies), 32'd1);
    check("rst_color", 32'(col), 32'(NONE));
    check("rst_bx", 32'(beam_x_out), 32'd0);
    check("rst_draw", 32'(draw_out), 32'd0);
    reset = 1'b0;
    tick();

    // Sparse frame sweep with an empty table
    for (int yy = 0; yy < 1024; yy += 257) begin
      for (int xx = 0; xx < 2048; xx += 511) begin
        px(11'(xx), 10'(yy), 1'b1, 1'b1, NONE, "sweep");
      end
    end
    check("sweep_wr_ready", 32'(wr_ready), 32'd1);
    check("sweep_pending", 32'(commit_pending), 32'd0);

    // Slot 0 at (400,100); the frame-start pixel already sees it
    write_slot(3'd0, 11'd400, 10'd100, 1'b1);
    pulse_commit();
    check("s0_pending", 32'(commit_pending), 32'd1);
    check("s0_wr_ready", 32'(wr_ready), 32'd0);
    frame_start = 1'b1;
    px(11'd400, 10'd100, 1'b1, 1'b0, EDGE, "s0_top_left");
    check("s0_applied", 32'(commit_pending), 32'd0);
    px(11'd459, 10'd105, 1'b1, 1'b0, BODY, "s0_right_col");
    px(11'd460, 10'd105, 1'b1, 1'b1, NONE, "s0_past_right");
    px(11'd400, 10'd112, 1'b1, 1'b1, NONE, "s0_below");
    px(11'd400, 10'd111, 1'b1, 1'b0, EDGE, "s0_bottom_edge");
    px(11'd399, 10'd105, 1'b1, 1'b1, NONE, "s0_left_of");
    px(11'd420, 10'd105, 1'b0, 1'b1, NONE, "s0_no_draw");

    // Gating: writes refused while a commit is pending
    pulse_commit();
    wr_valid = 1'b1; wr_index = 3'd1; wr_x = 11'd0; wr_y = 10'd0; wr_active = 1'b1;
    #1;
    check("gate_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    wr_valid = 1'b0;
    pulse_frame();
    check("gate_ready_back", 32'(wr_ready), 32'd1);
    px(11'd10, 10'd5, 1'b1, 1'b1, NONE, "gate_slot1_empty");
    px(11'd430, 10'd105, 1'b1, 1'b0, BODY, "gate_slot0_kept");

    // Overlap: slot 2 body wins over slot 5 edge at (515,201)
    write_slot(3'd2, 11'd500, 10'd200, 1'b1);
    write_slot(3'd5, 11'd510, 10'd201, 1'b1);
    pulse_commit();
    pulse_frame();
    px(11'd515, 10'd201, 1'b1, 1'b0, BODY, "ovl_slot2_wins");
    px(11'd505, 10'd201, 1'b1, 1'b0, BODY, "ovl_slot2_only");
    // Disable slot 2 in the same cycle as the commit
    wr_valid = 1'b1; wr_index = 3'd2; wr_x = 11'd500; wr_y = 10'd200; wr_active = 1'b0;
    commit = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    pulse_frame();
    px(11'd515, 10'd201, 1'b1, 1'b0, EDGE, "ovl_slot5_now");
    px(11'd505, 10'd201, 1'b1, 1'b1, NONE, "ovl_slot2_gone");

    // Commit coinciding with frame start is applied one frame later
    write_slot(3'd3, 11'd100, 10'd300, 1'b1);
    commit = 1'b1; frame_start = 1'b1;
    tick();
    commit = 1'b0; frame_start = 1'b0;
    check("cf_still_pending", 32'(commit_pending), 32'd1);
    px(11'd100, 10'd305, 1'b1, 1'b1, NONE, "cf_not_yet");
    frame_start = 1'b1;
    px(11'd100, 10'd305, 1'b1, 1'b0, BODY, "cf_applied");

    // Edge arithmetic near the bottom-right corner
    write_slot(3'd4, 11'd2040, 10'd1020, 1'b1);
    pulse_commit();
    pulse_frame();
    px(11'd5, 10'd2, 1'b1, 1'b1, NONE, "corner_no_wrap");
    px(11'd2045, 10'd1021, 1'b1, 1'b0, BODY, "corner_hit");
    px(11'd2047, 10'd1020, 1'b1, 1'b0, EDGE, "corner_top_edge");

    // Alignment: beam and draw delayed exactly two cycles
    for (int i = 0; i < 24; i++) begin
      hx[i] = 11'($urandom);
      hy[i] = 10'($urandom);
      hd[i] = 1'($urandom);
      beam_x = hx[i]; beam_y = hy[i]; draw = hd[i];
      tick();
      if (i >= 1) begin
        check("align_bx", 32'(beam_x_out), 32'(hx[i-1]));
        check("align_by", 32'(beam_y_out), 32'(hy[i-1]));
        check("align_draw", 32'(draw_out), 32'(hd[i-1]));
      end
    end

    // Reset while a commit is pending
    write_slot(3'd6, 11'd700, 10'd400, 1'b1);
    pulse_commit();
    check("mr_pending_set", 32'(commit_pending), 32'd1);
    beam_x = 11'd400; beam_y = 10'd100; draw = 1'b1;
    reset = 1'b1;
    tick();
    check("mr_pending", 32'(commit_pending), 32'd0);
    check("mr_wr_ready", 32'(wr_ready), 32'd1);
    check("mr_transp", 32'(platform_transparencies), 32'd1);
    check("mr_bx", 32'(beam_x_out), 32'd0);
    reset = 1'b0;
    pulse_frame();
    px(11'd400, 10'd100, 1'b1, 1'b1, NONE, "mr_slot0_cleared");
    px(11'd2045, 10'd1021, 1'b1, 1'b1, NONE, "mr_slot4_cleared");
    px(11'd710, 10'd405, 1'b1, 1'b1, NONE, "mr_slot6_dropped");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
